// File: rtl/biu_constants_pkg.sv
// Shared BIU transfer attribute types and the burst-type to beat-count helper.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE   = 3'd0,
        HWORD  = 3'd1,
        WORD   = 3'd2,
        DWORD  = 3'd3,
        QWORD  = 3'd4,
        OWORD  = 3'd5,
        HOWORD = 3'd6,
        KWORD  = 3'd7
    } biu_size_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } biu_type_t;

    typedef logic [2:0] biu_prot_t;

    localparam biu_prot_t PROT_DATA       = 3'b000;
    localparam biu_prot_t PROT_PRIVILEGED = 3'b001;
    localparam biu_prot_t PROT_NONSECURE  = 3'b010;
    localparam biu_prot_t PROT_INSTR      = 3'b100;

    // INCR is an undefined-length burst; the arbiter treats it as one beat.
    function automatic logic [4:0] biu_type2beats(input biu_type_t t);
        logic [4:0] beats;
        case (t)
            WRAP4, INCR4:   beats = 5'd4;
            WRAP8, INCR8:   beats = 5'd8;
            WRAP16, INCR16: beats = 5'd16;
            default:        beats = 5'd1;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/biu_arbiter2_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the port that was not last served wins.
module biu_rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/biu_arbiter2.sv
// Round-robin arbiter sharing one BIU master port between instruction fetch (port 0)
// and data (port 1); the grant is held for a whole transfer and across locked sequences.
module biu_arbiter2
    import biu_constants_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = DATA_SIZE
) (
    input  logic                 ACLK,
    input  logic                 ARESET,

    input  logic                 m0_stb_i,
    output logic                 m0_stb_ack_o,
    output logic                 m0_d_ack_o,
    input  logic [ADDR_SIZE-1:0] m0_adri_i,
    output logic [ADDR_SIZE-1:0] m0_adro_o,
    input  biu_size_t            m0_size_i,
    input  biu_type_t            m0_type_i,
    input  biu_prot_t            m0_prot_i,
    input  logic                 m0_lock_i,
    input  logic                 m0_we_i,
    input  logic [DATA_SIZE-1:0] m0_d_i,
    output logic [DATA_SIZE-1:0] m0_q_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,

    input  logic                 m1_stb_i,
    output logic                 m1_stb_ack_o,
    output logic                 m1_d_ack_o,
    input  logic [ADDR_SIZE-1:0] m1_adri_i,
    output logic [ADDR_SIZE-1:0] m1_adro_o,
    input  biu_size_t            m1_size_i,
    input  biu_type_t            m1_type_i,
    input  biu_prot_t            m1_prot_i,
    input  logic                 m1_lock_i,
    input  logic                 m1_we_i,
    input  logic [DATA_SIZE-1:0] m1_d_i,
    output logic [DATA_SIZE-1:0] m1_q_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,

    output logic                 s_stb_o,
    output logic                 s_lock_o,
    output logic                 s_we_o,
    output logic [ADDR_SIZE-1:0] s_adri_o,
    output biu_size_t            s_size_o,
    output biu_type_t            s_type_o,
    output biu_prot_t            s_prot_o,
    output logic [DATA_SIZE-1:0] s_d_o,
    input  logic                 s_stb_ack_i,
    input  logic                 s_d_ack_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    input  logic [ADDR_SIZE-1:0] s_adro_i,
    input  logic [DATA_SIZE-1:0] s_q_i,

    output logic                 owner_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;
    logic [4:0] beat_cnt_q, beat_cnt_d;
    logic       lock_q, lock_d;
    logic       we_q, we_d;

    logic [1:0] pick_gnt;

    logic                 own_stb;
    logic                 own_lock;
    logic                 own_we;
    logic [ADDR_SIZE-1:0] own_adri;
    biu_size_t            own_size;
    biu_type_t            own_type;
    biu_prot_t            own_prot;
    logic [DATA_SIZE-1:0] own_d;

    logic in_grant;
    logic in_wait;
    logic stb_ack_fwd;
    logic d_ack_fwd;
    logic ack_fwd;
    logic err_fwd;

    biu_rr_pick2 u_pick (
        .req_i  ({m1_stb_i, m0_stb_i}),
        .last_i (last_owner_q),
        .gnt_o  (pick_gnt)
    );

    // Request attributes always follow the current owner, so s_d_o stays valid during write beats.
    always_comb begin
        if (owner_q) begin
            own_stb  = m1_stb_i;
            own_lock = m1_lock_i;
            own_we   = m1_we_i;
            own_adri = m1_adri_i;
            own_size = m1_size_i;
            own_type = m1_type_i;
            own_prot = m1_prot_i;
            own_d    = m1_d_i;
        end else begin
            own_stb  = m0_stb_i;
            own_lock = m0_lock_i;
            own_we   = m0_we_i;
            own_adri = m0_adri_i;
            own_size = m0_size_i;
            own_type = m0_type_i;
            own_prot = m0_prot_i;
            own_d    = m0_d_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        lock_d       = lock_q;
        we_d         = we_q;

        case (state_q)
            IDLE: begin
                if (m0_stb_i || m1_stb_i) begin
                    owner_d = pick_gnt[1] & ~pick_gnt[0];
                    state_d = GRANT;
                end
            end

            GRANT: begin
                if (own_stb && s_stb_ack_i) begin
                    beat_cnt_d = biu_type2beats(own_type);
                    lock_d     = own_lock;
                    we_d       = own_we;
                    state_d    = WAIT;
                end else if (!own_stb && !lock_q) begin
                    state_d = IDLE;
                end
            end

            WAIT: begin
                if (s_err_i) begin
                    beat_cnt_d   = 5'd0;
                    lock_d       = 1'b0;
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end else if (s_ack_i) begin
                    beat_cnt_d = beat_cnt_q - 5'd1;
                    if (beat_cnt_q == 5'd1) begin
                        if (lock_q) begin
                            state_d = GRANT;
                        end else begin
                            last_owner_d = owner_q;
                            state_d      = IDLE;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            beat_cnt_q   <= 5'd0;
            lock_q       <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            lock_q       <= lock_d;
            we_q         <= we_d;
        end
    end

    assign in_grant = (state_q == GRANT);
    assign in_wait  = (state_q == WAIT);

    assign s_stb_o  = in_grant & own_stb;
    assign s_lock_o = in_grant ? own_lock : (in_wait & lock_q);
    assign s_we_o   = in_wait ? we_q : own_we;
    assign s_adri_o = own_adri;
    assign s_size_o = own_size;
    assign s_type_o = own_type;
    assign s_prot_o = own_prot;
    assign s_d_o    = own_d;

    // Acks outside WAIT are spurious and dropped; d_ack may accompany stb_ack in GRANT.
    assign stb_ack_fwd = in_grant & s_stb_ack_i;
    assign d_ack_fwd   = (in_grant | in_wait) & s_d_ack_i;
    assign ack_fwd     = in_wait & s_ack_i;
    assign err_fwd     = in_wait & s_err_i;

    assign m0_stb_ack_o = stb_ack_fwd & ~owner_q;
    assign m0_d_ack_o   = d_ack_fwd   & ~owner_q;
    assign m0_ack_o     = ack_fwd     & ~owner_q;
    assign m0_err_o     = err_fwd     & ~owner_q;

    assign m1_stb_ack_o = stb_ack_fwd & owner_q;
    assign m1_d_ack_o   = d_ack_fwd   & owner_q;
    assign m1_ack_o     = ack_fwd     & owner_q;
    assign m1_err_o     = err_fwd     & owner_q;

    assign m0_q_o    = s_q_i;
    assign m1_q_o    = s_q_i;
    assign m0_adro_o = s_adro_i;
    assign m1_adro_o = s_adro_i;

    assign owner_o = owner_q;

endmodule
